// File: rtl/flash_readback.sv
// flash_readback: dumps a region of the SPI configuration flash out of the
// UART TX pin using one JEDEC READ (0x03) transaction. SCLK is held low
// between bytes whenever the single-byte holding register is still occupied.
module flash_readback #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [23:0] length,
  output logic        busy,
  output logic        done,
  output logic        f_sclk,
  output logic        f_cs,
  output logic        f_mosi,
  input  logic        f_miso,
  output logic        tx
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, CMD, READ, FLUSH} state_t;

  state_t             state_q, state_d;
  logic               done_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [5:0]         bit_cnt;
  logic [31:0]        cmd_sr;
  logic [7:0]         asm_sr;
  logic [23:0]        remaining;
  logic               last_byte;
  logic               byte_rdy;
  logic [7:0]         hold;
  logic               hold_full;
  logic               uart_busy;
  logic [8:0]         u_sr;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [3:0]         u_bit;

  logic accept, spi_active, tick, stall, rise_ev, fall_ev;
  logic byte_end, uart_load, uart_end;

  assign accept     = (state_q == IDLE) && start && (length != '0);
  assign spi_active = (state_q == CMD) || (state_q == READ);
  assign tick       = (div_cnt == DIV_MAX);
  // A new byte may not begin clocking until the previous one has left the holding register.
  assign stall      = (state_q == READ) && !f_sclk && (bit_cnt == 6'd0) && (hold_full || byte_rdy);
  assign rise_ev    = spi_active && tick && !f_sclk && !stall;
  assign fall_ev    = spi_active && tick && f_sclk;
  assign byte_end   = rise_ev && (state_q == READ) && (bit_cnt == 6'd7);
  assign uart_load  = !uart_busy && hold_full;
  assign uart_end   = uart_busy && (baud_cnt == BAUD_MAX) && (u_bit == 4'd9);

  assign busy   = (state_q != IDLE);
  assign f_cs   = !spi_active;
  assign f_mosi = cmd_sr[31];

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // Next-state logic; done is decided one cycle ahead so it lands right after the stop bit.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0) done_d = 1'b1;
          else              state_d = CMD;
        end
      end
      CMD:   if (fall_ev && (bit_cnt == 6'd32)) state_d = READ;
      READ:  if (fall_ev && last_byte)          state_d = FLUSH;
      FLUSH: begin
        if (!hold_full && !byte_rdy && (!uart_busy || uart_end)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SPI clock divider, command shifter and read byte assembler.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      f_sclk    <= 1'b0;
      cmd_sr    <= '0;
      asm_sr    <= '0;
      last_byte <= 1'b0;
    end else if (accept) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      f_sclk    <= 1'b0;
      cmd_sr    <= {8'h03, base_addr};
      last_byte <= 1'b0;
    end else if (spi_active) begin
      // While stalled the divider parks at its terminal count so SCLK rises as soon as allowed.
      if (!tick)       div_cnt <= div_cnt + 1'b1;
      else if (!stall) div_cnt <= '0;
      if (rise_ev) begin
        f_sclk <= 1'b1;
        if (state_q == CMD) begin
          bit_cnt <= bit_cnt + 6'd1;
        end else begin
          asm_sr <= {asm_sr[6:0], f_miso};
          if (bit_cnt == 6'd7) begin
            bit_cnt   <= '0;
            last_byte <= (remaining == 24'd1);
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
      end
      if (fall_ev) begin
        f_sclk <= 1'b0;
        cmd_sr <= {cmd_sr[30:0], 1'b0};
        if ((state_q == CMD) && (bit_cnt == 6'd32)) bit_cnt <= '0;
      end
    end
  end

  // Holding register, byte counter and 8N1 transmitter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_rdy  <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      remaining <= '0;
      uart_busy <= 1'b0;
      u_sr      <= '0;
      baud_cnt  <= '0;
      u_bit     <= '0;
      tx        <= 1'b1;
    end else begin
      byte_rdy <= byte_end;
      if (accept)        remaining <= length;
      else if (byte_rdy) remaining <= remaining - 24'd1;
      if (byte_rdy) begin
        hold      <= asm_sr;
        hold_full <= 1'b1;
      end else if (uart_load) begin
        hold_full <= 1'b0;
      end
      if (uart_load) begin
        uart_busy <= 1'b1;
        u_sr      <= {1'b1, hold};
        tx        <= 1'b0;
        baud_cnt  <= '0;
        u_bit     <= '0;
      end else if (uart_busy) begin
        if (baud_cnt != BAUD_MAX) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          if (u_bit == 4'd9) begin
            uart_busy <= 1'b0;
          end else begin
            tx    <= u_sr[0];
            u_sr  <= {1'b1, u_sr[8:1]};
            u_bit <= u_bit + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_readback.sv
// Scoreboard bench for flash_readback: stimulus pushes expected SPI commands,
// UART bytes and done pulses; independent monitors pop and compare.
module tb_flash_readback;

  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned BAUD_DIV = 16;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [23:0] base_addr = '0;
  logic [23:0] length = '0;
  logic        busy, done, f_sclk, f_cs, f_mosi, tx;
  logic        f_miso = 1'b0;

  flash_readback #(.CLK_DIV(CLK_DIV), .BAUD_DIV(BAUD_DIV)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .f_sclk(f_sclk), .f_cs(f_cs),
    .f_mosi(f_mosi), .f_miso(f_miso), .tx(tx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash content: every byte is its address low byte plus 0x60.
  function automatic logic [7:0] mem(input logic [23:0] a);
    return 8'(a[7:0] + 8'h60);
  endfunction

  typedef struct {
    bit          zero;
    int unsigned cyc;
  } done_exp_t;

  logic [31:0] exp_cmd_q[$];
  int unsigned exp_rises_q[$];
  logic [7:0]  exp_byte_q[$];
  done_exp_t   done_q[$];

  // ---------------- flash model (SPI mode 0) ----------------
  logic [31:0] cmd_cap = '0;
  int unsigned rises = 0;
  int unsigned cs_falls = 0;
  int unsigned mosi_bad = 0;

  always @(posedge f_sclk or negedge f_cs) begin
    if (!f_sclk) begin
      cs_falls++;
      rises    = 0;
      cmd_cap  = '0;
      mosi_bad = 0;
    end else if (!f_cs) begin
      if (rises < 32) cmd_cap = {cmd_cap[30:0], f_mosi};
      else if (f_mosi) mosi_bad++;
      rises++;
    end
  end

  int unsigned fk;
  logic [7:0]  fb;
  always @(negedge f_sclk) begin
    if (!f_cs && rises >= 32) begin
      fk = rises - 32;
      fb = mem(cmd_cap[23:0] + 24'(fk / 8));
      f_miso = fb[7 - (fk % 8)];
    end
  end

  // ---------------- pin monitors ----------------
  logic        sclk_prev = 1'b0;
  logic        mosi_prev = 1'b0;
  int unsigned low_run = 0;
  int unsigned max_low = 0;

  always @(negedge clk) begin
    if (f_mosi !== mosi_prev) check("mosi_changes_while_sclk_low", 32'(f_sclk), 0);
    mosi_prev = f_mosi;
    sclk_prev = f_sclk;
    if (!f_cs && !f_sclk) low_run++;
    else low_run = 0;
    if (low_run > max_low) max_low = low_run;
  end

  // SPI transaction end: command word, edge count, CS/SCLK alignment.
  initial begin : spi_mon
    logic [31:0] e_cmd;
    int unsigned e_r;
    forever begin
      @(posedge f_cs);
      #1;
      if (n_rst) begin
        check("spi_txn_expected", 32'(exp_cmd_q.size() != 0), 1);
        if (exp_cmd_q.size() != 0) begin
          e_cmd = exp_cmd_q.pop_front();
          e_r   = exp_rises_q.pop_front();
          check("mosi_command", cmd_cap, e_cmd);
          check("sclk_rise_count", rises, e_r);
          check("mosi_low_in_read", mosi_bad, 0);
          check("cs_rises_with_sclk_fall", 32'({f_sclk, sclk_prev}), 32'h1);
        end
      end
    end
  end

  // UART decoder: samples mid-bit, pops expected bytes.
  bit          u_act = 1'b0;
  int unsigned u_cnt = 0;
  int unsigned u_start = 0;
  int unsigned last_done_exp = 0;
  logic [7:0]  u_byte = '0;
  logic [7:0]  u_exp;

  always @(negedge clk) begin
    if (!n_rst) begin
      u_act = 1'b0;
    end else if (!u_act) begin
      if (tx === 1'b0) begin
        u_act   = 1'b1;
        u_cnt   = 0;
        u_start = cyc;
      end
    end else begin
      u_cnt++;
      if (u_cnt % BAUD_DIV == BAUD_DIV / 2) begin
        if (u_cnt / BAUD_DIV == 0) begin
          check("uart_start_bit", 32'(tx), 0);
        end else if (u_cnt / BAUD_DIV <= 8) begin
          u_byte[u_cnt / BAUD_DIV - 1] = tx;
        end else begin
          check("uart_stop_bit", 32'(tx), 1);
          check("uart_byte_expected", 32'(exp_byte_q.size() != 0), 1);
          if (exp_byte_q.size() != 0) begin
            u_exp = exp_byte_q.pop_front();
            check("uart_byte", 32'(u_byte), 32'(u_exp));
          end
          last_done_exp = u_start + 10 * BAUD_DIV;
          u_act = 1'b0;
        end
      end
    end
  end
  initial u_cnt = 0;

  // done monitor: timing against last stop bit or zero-length request.
  int unsigned dones = 0;
  logic        done_prev = 1'b0;
  done_exp_t   d_e;
  always @(negedge clk) begin
    if (n_rst && done) begin
      dones++;
      check("done_single_cycle", 32'(done_prev), 0);
      check("done_expected", 32'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        d_e = done_q.pop_front();
        check("done_cycle", cyc, d_e.zero ? d_e.cyc + 1 : last_done_exp);
        check("busy_low_at_done", 32'(busy), 0);
      end
    end
    done_prev = done;
  end

  // ---------------- stimulus ----------------
  int unsigned t0 = 0;

  task automatic expect_xfer(input logic [23:0] a, input logic [23:0] l);
    done_exp_t e;
    exp_cmd_q.push_back({8'h03, a});
    exp_rises_q.push_back(32 + 8 * int'(l));
    for (int unsigned i = 0; i < l; i++) exp_byte_q.push_back(mem(a + 24'(i)));
    e.zero = 1'b0;
    e.cyc  = 0;
    done_q.push_back(e);
  endtask

  task automatic issue(input logic [23:0] a, input logic [23:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = a; length = l; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_launch(input logic [23:0] a);
    int unsigned n;
    logic [31:0] w;
    w = {8'h03, a};
    check("busy_cycle1", 32'(busy), 1);
    check("cs_low_cycle1", 32'(f_cs), 0);
    check("mosi_bit31_cycle1", 32'(f_mosi), 32'(w[31]));
    n = 1;
    while (!f_sclk && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_sclk_rise_cycle", n, 1 + CLK_DIV);
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (dones < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 32'(dones >= target), 1);
  endtask

  initial begin : main
    int unsigned bad, d0, f0, n;
    done_exp_t ez;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_cs", 32'(f_cs), 1);
    check("rst_sclk", 32'(f_sclk), 0);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    n_rst = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (f_cs !== 1'b1 || f_sclk !== 1'b0 || tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_outputs_stable", bad, 0);

    // single byte
    d0 = dones;
    expect_xfer(24'h012345, 24'd1);
    issue(24'h012345, 24'd1);
    check_launch(24'h012345);
    wait_done(d0 + 1, 2000);

    // stall: UART slower than SPI
    d0 = dones;
    expect_xfer(24'h0000A0, 24'd4);
    issue(24'h0000A0, 24'd4);
    check_launch(24'h0000A0);
    wait_done(d0 + 1, 4000);
    check("sclk_stalled_between_bytes", 32'(max_low > 40), 1);

    // zero length
    d0 = dones;
    f0 = cs_falls;
    @(negedge clk);
    start = 1'b1; base_addr = 24'h000777; length = 24'd0;
    ez.zero = 1'b1; ez.cyc = cyc;
    done_q.push_back(ez);
    @(negedge clk);
    start = 1'b0;
    check("zero_len_done_next_cycle", 32'(done), 1);
    check("zero_len_busy", 32'(busy), 0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || f_cs !== 1'b1) bad++;
    end
    check("zero_len_stays_idle", bad, 0);
    check("zero_len_no_cs_fall", cs_falls, f0);
    check("zero_len_one_done", dones, d0 + 1);

    // start while busy is ignored
    d0 = dones;
    expect_xfer(24'h000010, 24'd2);
    issue(24'h000010, 24'd2);
    check_launch(24'h000010);
    repeat (100) @(negedge clk);
    start = 1'b1; base_addr = 24'h0000F0; length = 24'd3;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_ignored_start", 32'(busy), 1);
    wait_done(d0 + 1, 3000);
    repeat (400) @(negedge clk);
    check("ignored_start_one_done", dones, d0 + 1);
    check("ignored_start_idle_busy", 32'(busy), 0);
    check("ignored_start_idle_cs", 32'(f_cs), 1);

    // reset during the second byte of four
    expect_xfer(24'h000200, 24'd4);
    issue(24'h000200, 24'd4);
    check_launch(24'h000200);
    n = 0;
    while (rises < 42 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_second_byte", 32'(rises >= 42), 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst_cs", 32'(f_cs), 1);
    check("midrst_tx", 32'(tx), 1);
    check("midrst_sclk", 32'(f_sclk), 0);
    check("midrst_busy", 32'(busy), 0);
    exp_cmd_q.delete();
    exp_rises_q.delete();
    exp_byte_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    d0 = dones;
    expect_xfer(24'h000300, 24'd2);
    issue(24'h000300, 24'd2);
    check_launch(24'h000300);
    wait_done(d0 + 1, 3000);

    repeat (20) @(negedge clk);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 0);
    check("byte_queue_drained", 32'(exp_byte_q.size()), 0);
    check("done_queue_drained", 32'(done_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
